ring_endpoint: RTL and testbench
================================

// Module: ring_endpoint
// PURPOSE
//  Core-side network interface for one ring node: opposite end of the ring's
//  per-node inject/eject ports. Queues core packets, stamps src, offers them to
//  the ring until accepted; captures every ejected packet into an RX queue
//  drained by the core via valid/ready. One instance per node.
//  Self-addressed packets loop back locally and never enter the ring.
// PARAMETERS
//  NODE_ID     0    this node's id; stamped into src, compared against dest
//  ID_SIZE     8    width of src/dest fields
//  DATA_WIDTH  128  payload width; PKT_W = 2*ID_SIZE+DATA_WIDTH
//  TXQ_DEPTH   4    TX queue entries, power of 2, >=2
//  RXQ_DEPTH   4    RX queue entries, power of 2, >=2
//  STARVE_LIM  16   consecutive unaccepted offer cycles that raise tx_starved
// PORTS
//  clk            in   1           clock, all state on posedge
//  rst            in   1           asynchronous, active-high reset
//  core_tx_valid  in   1           core has a packet to send
//  core_tx_dest   in   ID_SIZE     destination node
//  core_tx_data   in   DATA_WIDTH  payload
//  core_tx_ready  out  1           TX queue can take a packet this cycle
//  net_pkt_out    out  PKT_W       {src,dest,data} offered to ring (packetSendIn)
//  net_pkt_valid  out  1           offer valid (drives packetCoreIn)
//  net_accept     in   1           ring took net_pkt_out this cycle (recievedOut)
//  net_rx_valid   in   1           ring ejects a packet to this node (recieved)
//  net_rx_pkt     in   PKT_W       ejected packet {src,dest,data}
//  core_rx_valid  out  1           RX queue head valid
//  core_rx_src    out  ID_SIZE     head src
//  core_rx_data   out  DATA_WIDTH  head payload
//  core_rx_ready  in   1           core pops RX head
//  rx_drop_cnt    out  8           saturating count of ejected packets dropped
//  tx_starved     out  1           offer unaccepted for >= STARVE_LIM cycles
// BEHAVIOUR
//  Reset: both queues empty; core_tx_ready=1, net_pkt_valid=0, core_rx_valid=0,
//   rx_drop_cnt=0, tx_starved=0, wait counter=0, TX FSM=IDLE. Asserting rst
//   mid-offer discards queued and in-flight packets; nothing is replayed.
//  TX enqueue: fire = core_tx_valid & core_tx_ready, core_tx_ready = ~txq_full.
//   dest!=NODE_ID -> push {NODE_ID,dest,data} into TX queue on fire.
//   dest==NODE_ID -> loopback path (below); core_tx_ready is additionally low
//   for a loopback packet when loopback cannot write this cycle.
//  TX FSM: IDLE: txq empty, net_pkt_valid=0; -> OFFER when txq non-empty
//   (registered, so earliest offer is the cycle after enqueue).
//   OFFER: net_pkt_valid=1, net_pkt_out=txq head, held stable until accept.
//   net_accept high -> pop head; stay OFFER if more entries, else -> IDLE.
//   net_accept is ignored while net_pkt_valid=0. Enqueue and pop in the same
//   cycle are both honoured (count unchanged), including when txq is full.
//  Starvation: wait counter +1 per OFFER cycle without accept, saturates at
//   STARVE_LIM, clears on accept or IDLE; tx_starved = (wait==STARVE_LIM).
//  RX: ring ejection has no backpressure. net_rx_valid -> push net_rx_pkt into
//   RX queue same edge; if rxq full and no pop this cycle -> drop, rx_drop_cnt+1
//   (saturates 255). Push and pop in same cycle on a full queue: push accepted.
//   net_rx_pkt.dest is not rechecked.
//  Loopback: one RX write port; network ejection has priority. Loopback writes
//   only when net_rx_valid=0 and rxq not full (or popping this cycle).
//  RX head: core_rx_valid = ~rxq_empty; src/data are combinational from head;
//   pop on core_rx_valid & core_rx_ready. Order preserved per queue.
//  Pointers wrap modulo depth; counts are log2(DEPTH)+1 bits to tell full/empty.
// TESTING
//  1 NODE_ID=0: send dest=2,data=0x1234; hold net_accept=0 3 cyc then 1 ->
//    net_pkt_out={0,2,0x1234} stable 4 cyc, net_pkt_valid drops next cycle.
//  2 Fill TXQ with 4 pkts, net_accept=0 -> core_tx_ready=0; STARVE_LIM=16
//    cycles later tx_starved=1; single accept -> tx_starved=0, core_tx_ready=1.
//  3 net_rx_valid 6 cyc, core_rx_ready=0 -> 4 queued, rx_drop_cnt=2; drain ->
//    core_rx_src/data in arrival order of first 4.
//  4 NODE_ID=1: send dest=1,data=0xAB -> core_rx_valid next cycle src=1,
//    data=0xAB, net_pkt_valid never asserted; with concurrent net_rx_valid
//    the network packet is queued first.
//  5 Full TXQ, enqueue+accept same cycle -> count stays 4, FIFO order kept.
//  6 Assert rst while OFFER with 3 queued -> all outputs to reset values
//    immediately (async), rx_drop_cnt=0, no stale offer after release.

Source files
------------

// File: rtl/ring_endpoint.sv
// Core-side ring node interface: TX queue with offer FSM toward the ring,
// RX queue fed by ring ejection and local loopback, drained by the core.
module ring_endpoint #(
   parameter int NODE_ID    = 0,
   parameter int ID_SIZE    = 8,
   parameter int DATA_WIDTH = 128,
   parameter int TXQ_DEPTH  = 4,
   parameter int RXQ_DEPTH  = 4,
   parameter int STARVE_LIM = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            core_tx_valid,
   input  logic [ID_SIZE-1:0]              core_tx_dest,
   input  logic [DATA_WIDTH-1:0]           core_tx_data,
   output logic                            core_tx_ready,
   output logic [2*ID_SIZE+DATA_WIDTH-1:0] net_pkt_out,
   output logic                            net_pkt_valid,
   input  logic                            net_accept,
   input  logic                            net_rx_valid,
   input  logic [2*ID_SIZE+DATA_WIDTH-1:0] net_rx_pkt,
   output logic                            core_rx_valid,
   output logic [ID_SIZE-1:0]              core_rx_src,
   output logic [DATA_WIDTH-1:0]           core_rx_data,
   input  logic                            core_rx_ready,
   output logic [7:0]                      rx_drop_cnt,
   output logic                            tx_starved
);

   localparam int PKT_W = 2*ID_SIZE+DATA_WIDTH;
   localparam int RX_W  = ID_SIZE+DATA_WIDTH;
   localparam int TXA   = $clog2(TXQ_DEPTH);
   localparam int RXA   = $clog2(RXQ_DEPTH);
   localparam int WW    = $clog2(STARVE_LIM+1);

   localparam logic [ID_SIZE-1:0] SELF    = ID_SIZE'(NODE_ID);
   localparam logic [TXA:0]       TX_FULL = (TXA+1)'(TXQ_DEPTH);
   localparam logic [RXA:0]       RX_FULL = (RXA+1)'(RXQ_DEPTH);
   localparam logic [WW-1:0]      WLIM    = WW'(STARVE_LIM);

   typedef enum logic {IDLE, OFFER} tx_state_t;

   tx_state_t state, state_d;

   logic [PKT_W-1:0] txq [TXQ_DEPTH];
   logic [TXA-1:0]   tx_wp, tx_rp;
   logic [TXA:0]     tx_cnt, tx_cnt_d;

   logic [RX_W-1:0]  rxq [RXQ_DEPTH];
   logic [RXA-1:0]   rx_wp, rx_rp;
   logic [RXA:0]     rx_cnt, rx_cnt_d;

   logic [WW-1:0]    wait_cnt;

   logic txq_full, rxq_full, rxq_empty;
   logic is_loop, lb_ok, fire;
   logic tx_push, tx_pop, lb_push;
   logic rx_push, rx_pop, rx_drop;
   logic [RX_W-1:0] rx_din;
   logic rx_dest_unused;

   assign txq_full  = (tx_cnt == TX_FULL);
   assign rxq_full  = (rx_cnt == RX_FULL);
   assign rxq_empty = (rx_cnt == '0);

   assign rx_pop  = ~rxq_empty & core_rx_ready;
   assign tx_pop  = (state == OFFER) & net_accept;
   assign is_loop = (core_tx_dest == SELF);

   // ring ejection owns the single RX write port
   assign lb_ok = ~net_rx_valid & (~rxq_full | rx_pop);

   assign core_tx_ready = (~txq_full | tx_pop) & (~is_loop | lb_ok);

   assign fire    = core_tx_valid & core_tx_ready;
   assign tx_push = fire & ~is_loop;
   assign lb_push = fire & is_loop;

   assign rx_push = net_rx_valid ? (~rxq_full | rx_pop) : lb_push;
   assign rx_drop = net_rx_valid & rxq_full & ~rx_pop;
   assign rx_din  = net_rx_valid ?
                    {net_rx_pkt[PKT_W-1 -: ID_SIZE],
                     net_rx_pkt[DATA_WIDTH-1:0]} :
                    {SELF, core_tx_data};

   assign rx_dest_unused = ^net_rx_pkt[DATA_WIDTH +: ID_SIZE];

   assign net_pkt_valid = (state == OFFER);
   assign net_pkt_out   = txq[tx_rp];
   assign tx_starved    = (wait_cnt == WLIM);

   assign core_rx_valid = ~rxq_empty;
   assign core_rx_src   = rxq[rx_rp][RX_W-1 -: ID_SIZE];
   assign core_rx_data  = rxq[rx_rp][DATA_WIDTH-1:0];

   always_comb begin
      tx_cnt_d = tx_cnt;
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt + 1'b1;
         2'b01:   tx_cnt_d = tx_cnt - 1'b1;
         default: tx_cnt_d = tx_cnt;
      endcase
   end

   always_comb begin
      rx_cnt_d = rx_cnt;
      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt + 1'b1;
         2'b01:   rx_cnt_d = rx_cnt - 1'b1;
         default: rx_cnt_d = rx_cnt;
      endcase
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:  if (tx_push) state_d = OFFER;
         OFFER: if (tx_cnt_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + TXA'(1);
         if (tx_pop)  tx_rp <= tx_rp + TXA'(1);
         tx_cnt <= tx_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) txq[tx_wp] <= {SELF, core_tx_dest, core_tx_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + RXA'(1);
         if (rx_pop)  rx_rp <= rx_rp + RXA'(1);
         rx_cnt <= rx_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rxq[rx_wp] <= rx_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         rx_drop_cnt <= '0;
      end else begin
         if (state == OFFER && !net_accept) begin
            if (wait_cnt != WLIM) wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (rx_drop && rx_drop_cnt != 8'hff)
            rx_drop_cnt <= rx_drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ring_endpoint.sv
// Bench for ring_endpoint: queue-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ring_endpoint;

   localparam int NODE = 1;
   localparam int IDW  = 8;
   localparam int DW   = 128;
   localparam int PW   = 2*IDW+DW;
   localparam int LIM  = 16;
   localparam int QD   = 4;

   typedef logic [PW-1:0]     pkt_t;
   typedef logic [IDW+DW-1:0] rxe_t;

   logic clk = 1'b0;
   logic rst;
   logic core_tx_valid;
   logic [IDW-1:0] core_tx_dest;
   logic [DW-1:0] core_tx_data;
   logic core_tx_ready;
   logic [PW-1:0] net_pkt_out;
   logic net_pkt_valid;
   logic net_accept;
   logic net_rx_valid;
   logic [PW-1:0] net_rx_pkt;
   logic core_rx_valid;
   logic [IDW-1:0] core_rx_src;
   logic [DW-1:0] core_rx_data;
   logic core_rx_ready;
   logic [7:0] rx_drop_cnt;
   logic tx_starved;

   always #5 clk = ~clk;

   ring_endpoint #(
      .NODE_ID(NODE), .ID_SIZE(IDW), .DATA_WIDTH(DW),
      .TXQ_DEPTH(QD), .RXQ_DEPTH(QD), .STARVE_LIM(LIM)
   ) dut (
      .clk(clk), .rst(rst),
      .core_tx_valid(core_tx_valid), .core_tx_dest(core_tx_dest),
      .core_tx_data(core_tx_data), .core_tx_ready(core_tx_ready),
      .net_pkt_out(net_pkt_out), .net_pkt_valid(net_pkt_valid),
      .net_accept(net_accept), .net_rx_valid(net_rx_valid),
      .net_rx_pkt(net_rx_pkt), .core_rx_valid(core_rx_valid),
      .core_rx_src(core_rx_src), .core_rx_data(core_rx_data),
      .core_rx_ready(core_rx_ready), .rx_drop_cnt(rx_drop_cnt),
      .tx_starved(tx_starved)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input pkt_t act, input pkt_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: plain queues and counters
   pkt_t txq[$];
   rxe_t rxq[$];
   int drops = 0;
   int wt = 0;
   bit m_rdy, m_txpop, m_rxpop, m_fire;

   function automatic bit m_ready();
      bit txpop = (txq.size() != 0) && net_accept;
      bit rxpop = (rxq.size() != 0) && core_rx_ready;
      bit r = (txq.size() < QD) || txpop;
      if (core_tx_dest == IDW'(NODE) &&
          (net_rx_valid || (rxq.size() == QD && !rxpop)))
         r = 1'b0;
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         txq.delete();
         rxq.delete();
         drops = 0;
         wt = 0;
      end else begin
         m_rdy   = m_ready();
         m_txpop = (txq.size() != 0) && net_accept;
         m_rxpop = (rxq.size() != 0) && core_rx_ready;
         m_fire  = core_tx_valid && m_rdy;
         if (txq.size() != 0 && !net_accept) wt = (wt < LIM) ? wt + 1 : LIM;
         else wt = 0;
         if (m_txpop) void'(txq.pop_front());
         if (m_fire && core_tx_dest != IDW'(NODE))
            txq.push_back({IDW'(NODE), core_tx_dest, core_tx_data});
         if (m_rxpop) void'(rxq.pop_front());
         if (net_rx_valid) begin
            if (rxq.size() < QD)
               rxq.push_back({net_rx_pkt[PW-1 -: IDW], net_rx_pkt[DW-1:0]});
            else if (drops < 255)
               drops = drops + 1;
         end else if (m_fire && core_tx_dest == IDW'(NODE)) begin
            rxq.push_back({IDW'(NODE), core_tx_data});
         end
      end
   end

   always @(negedge clk) begin
      chk("tx_ready", PW'(core_tx_ready), PW'(m_ready()));
      chk("pkt_valid", PW'(net_pkt_valid), PW'(txq.size() != 0));
      if (txq.size() != 0) chk("pkt_out", net_pkt_out, txq[0]);
      chk("rx_valid", PW'(core_rx_valid), PW'(rxq.size() != 0));
      if (rxq.size() != 0)
         chk("rx_head", PW'({core_rx_src, core_rx_data}), PW'(rxq[0]));
      chk("drop_cnt", PW'(rx_drop_cnt), PW'(drops));
      chk("starved", PW'(tx_starved), PW'(wt >= LIM));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_tx_valid = 1'b0;
      core_tx_dest  = '0;
      core_tx_data  = '0;
      net_accept    = 1'b0;
      net_rx_valid  = 1'b0;
      net_rx_pkt    = '0;
      core_rx_ready = 1'b0;
   endtask

   logic [DW-1:0] ex5 [4];
   int n;

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_ready", PW'(core_tx_ready), PW'(1));
      chk("rst_pkt_valid", PW'(net_pkt_valid), PW'(0));
      chk("rst_rx_valid", PW'(core_rx_valid), PW'(0));
      chk("rst_drop", PW'(rx_drop_cnt), PW'(0));
      chk("rst_starved", PW'(tx_starved), PW'(0));
      rst = 1'b0;
      tick();

      // offer held stable until accepted
      core_tx_valid = 1'b1;
      core_tx_dest  = 8'd2;
      core_tx_data  = 128'h1234;
      tick();
      core_tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         net_accept = (i == 3);
         #1;
         chk("t1_valid", PW'(net_pkt_valid), PW'(1));
         chk("t1_out", net_pkt_out, {8'd1, 8'd2, 128'h1234});
         tick();
      end
      net_accept = 1'b0;
      chk("t1_drop_valid", PW'(net_pkt_valid), PW'(0));

      // fill, starve, single accept
      core_tx_valid = 1'b1;
      core_tx_dest  = 8'd3;
      for (int i = 0; i < 4; i++) begin
         core_tx_data = DW'(10 + i);
         tick();
      end
      core_tx_valid = 1'b0;
      #1;
      chk("t2_full_ready", PW'(core_tx_ready), PW'(0));
      chk("t2_not_starved", PW'(tx_starved), PW'(0));
      n = 4;
      while (!tx_starved && n < 40) begin
         tick();
         n++;
      end
      chk("t2_starve_cycle", PW'(n), PW'(17));
      net_accept = 1'b1;
      #1;
      chk("t2_pop_ready", PW'(core_tx_ready), PW'(1));
      tick();
      net_accept = 1'b0;
      #1;
      chk("t2_unstarved", PW'(tx_starved), PW'(0));
      chk("t2_ready", PW'(core_tx_ready), PW'(1));

      // refill, then enqueue and accept together while full
      core_tx_valid = 1'b1;
      core_tx_data  = 128'h50;
      tick();
      core_tx_data  = 128'h55;
      net_accept    = 1'b1;
      #1;
      chk("t5_full_pop_ready", PW'(core_tx_ready), PW'(1));
      tick();
      core_tx_valid = 1'b0;
      net_accept    = 1'b0;
      #1;
      chk("t5_still_full", PW'(core_tx_ready), PW'(0));
      ex5[0] = 128'd12;
      ex5[1] = 128'd13;
      ex5[2] = 128'h50;
      ex5[3] = 128'h55;
      net_accept = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t5_order", PW'(net_pkt_out[DW-1:0]), PW'(ex5[i]));
         tick();
      end
      net_accept = 1'b0;
      #1;
      chk("t5_empty", PW'(net_pkt_valid), PW'(0));

      // RX overflow then drain in arrival order
      net_rx_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         net_rx_pkt = {8'(20 + i), 8'(NODE), 128'(100 + i)};
         tick();
      end
      net_rx_valid = 1'b0;
      #1;
      chk("t3_drops", PW'(rx_drop_cnt), PW'(2));
      core_rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_order", PW'({core_rx_src, core_rx_data}),
             PW'({8'(20 + i), 128'(100 + i)}));
         tick();
      end
      core_rx_ready = 1'b0;
      #1;
      chk("t3_empty", PW'(core_rx_valid), PW'(0));

      // loopback yields to concurrent ejection
      core_tx_valid = 1'b1;
      core_tx_dest  = 8'(NODE);
      core_tx_data  = 128'hAB;
      net_rx_valid  = 1'b1;
      net_rx_pkt    = {8'd7, 8'(NODE), 128'h77};
      #1;
      chk("t4_lb_blocked", PW'(core_tx_ready), PW'(0));
      tick();
      net_rx_valid = 1'b0;
      #1;
      chk("t4_lb_ready", PW'(core_tx_ready), PW'(1));
      tick();
      core_tx_valid = 1'b0;
      #1;
      chk("t4_no_offer", PW'(net_pkt_valid), PW'(0));
      chk("t4_net_first", PW'({core_rx_src, core_rx_data}),
          PW'({8'd7, 128'h77}));
      core_rx_ready = 1'b1;
      tick();
      chk("t4_loop_pkt", PW'({core_rx_src, core_rx_data}),
          PW'({8'd1, 128'hAB}));
      chk("t4_no_offer2", PW'(net_pkt_valid), PW'(0));
      tick();
      core_rx_ready = 1'b0;
      #1;
      chk("t4_empty", PW'(core_rx_valid), PW'(0));

      // drop counter saturation
      net_rx_valid = 1'b1;
      for (int i = 0; i < 265; i++) begin
         net_rx_pkt = {8'(i), 8'(NODE), {4{$urandom}}};
         tick();
      end
      net_rx_valid = 1'b0;
      #1;
      chk("drop_sat", PW'(rx_drop_cnt), PW'(255));

      // reset during an offer
      core_tx_valid = 1'b1;
      core_tx_dest  = 8'd4;
      for (int i = 0; i < 3; i++) begin
         core_tx_data = DW'(200 + i);
         tick();
      end
      core_tx_valid = 1'b0;
      #1;
      chk("t6_offering", PW'(net_pkt_valid), PW'(1));
      #1;
      rst = 1'b1;
      #1;
      chk("t6_valid", PW'(net_pkt_valid), PW'(0));
      chk("t6_rx_valid", PW'(core_rx_valid), PW'(0));
      chk("t6_drop", PW'(rx_drop_cnt), PW'(0));
      chk("t6_starved", PW'(tx_starved), PW'(0));
      chk("t6_ready", PW'(core_tx_ready), PW'(1));
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_stale", PW'(net_pkt_valid), PW'(0));
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         int mode;
         mode = (i / 300) % 3;
         rst = ($urandom_range(0, 699) == 0);
         core_tx_valid = $urandom_range(0, 1) == 1;
         core_tx_dest  = 8'($urandom_range(0, 3));
         core_tx_data  = {4{$urandom}};
         case (mode)
            0:       net_accept = $urandom_range(0, 3) != 0;
            1:       net_accept = $urandom_range(0, 19) == 0;
            default: net_accept = $urandom_range(0, 1) == 1;
         endcase
         net_rx_valid  = $urandom_range(0, 4) < 2;
         net_rx_pkt    = {8'($urandom), 8'(NODE), {4{$urandom}}};
         core_rx_ready = $urandom_range(0, 1) == 1;
         tick();
      end
      rst = 1'b0;
      idle();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
